// File: rtl/snd_req_queue.sv
// rtl/snd_req_queue.sv - sound request arbiter: normal-request FIFO, critical preemption, start/gap pacing
//
// Collects one-cycle sound event strobes, queues normal sounds (modes 1..5) in a
// small FIFO and issues them to the downstream sound manager with a silent gap
// between sounds. Critical sounds (6 gameover, 7 gameclear) flush the queue and
// preempt whatever is playing.
//
// Ports:
//   clk_1mhz  in   clock, all state on rising edge
//   rst       in   asynchronous active-high reset
//   ev_req    in   [6:0] event strobes, bit i requests mode i+1
//   playing   in   busy flag from the sound manager
//   snd_mode  out  [2:0] registered mode, held until next issue
//   trig      out  registered one-cycle start pulse
//   busy      out  FSM active, queue non-empty or critical pending
//   q_count   out  [2:0] queue occupancy
//   drop      out  registered one-cycle pulse when a request is discarded

module snd_req_queue #(
    parameter int DEPTH    = 4,
    parameter int START_TO = 8,
    parameter int GAP_CYC  = 20000
) (
    input  logic       clk_1mhz,
    input  logic       rst,
    input  logic [6:0] ev_req,
    input  logic       playing,
    output logic [2:0] snd_mode,
    output logic       trig,
    output logic       busy,
    output logic [2:0] q_count,
    output logic       drop
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int TW = (START_TO > 1) ? $clog2(START_TO) : 1;
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
    localparam logic [TW-1:0] TO_LAST  = TW'(START_TO - 1);
    localparam logic [GW-1:0] GAP_LOAD = (GAP_CYC > 1) ? GW'(GAP_CYC - 1) : '0;
    localparam logic [2:0]    DEPTH_Q  = 3'(DEPTH);
    localparam bit            GAP_NONE = (GAP_CYC == 0);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2,
        GAP        = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic [2:0]      fifo_mem [DEPTH];
    logic [PW-1:0]   wr_ptr, rd_ptr, tail_idx;
    logic            crit_pend;
    logic [2:0]      crit_mode;
    logic [TW-1:0]   to_cnt, to_nxt;
    logic [GW-1:0]   gap_cnt, gap_nxt;

    logic [2:0]      req_mode;
    logic            req_valid, req_crit, req_norm, multi_req, dup_beep;
    logic            issue, issue_crit, pop, push, drop_nxt;
    logic [2:0]      issue_mode;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    // Highest set bit wins; any additional set bit is a discarded request.
    always_comb begin
        req_mode = '0;
        for (int i = 0; i < 7; i++) begin
            if (ev_req[i]) req_mode = 3'(i + 1);
        end
    end

    assign req_valid = |ev_req;
    assign multi_req = (ev_req & (ev_req - 7'd1)) != 7'd0;
    assign req_crit  = req_valid && (req_mode >= 3'd6);
    assign req_norm  = req_valid && !req_crit;
    assign tail_idx  = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PW'(1);

    // A beep behind a beep adds nothing audible, so it is swallowed quietly.
    assign dup_beep = req_norm && (req_mode == 3'd1) && (q_count != 3'd0)
                      && (fifo_mem[tail_idx] == 3'd1);

    // Full FIFO still accepts when the head leaves in the same cycle.
    assign push     = req_norm && !dup_beep && ((q_count != DEPTH_Q) || pop);
    assign drop_nxt = multi_req || (req_norm && !dup_beep && !push);

    assign busy = (state != IDLE) || (q_count != 3'd0) || crit_pend;

    always_comb begin
        state_nxt  = state;
        issue      = 1'b0;
        issue_crit = 1'b0;
        issue_mode = crit_mode;
        pop        = 1'b0;
        to_nxt     = to_cnt;
        gap_nxt    = gap_cnt;

        if (crit_pend && !trig) begin
            issue      = 1'b1;
            issue_crit = 1'b1;
            issue_mode = crit_mode;
            to_nxt     = '0;
            state_nxt  = WAIT_START;
        end else if (crit_pend) begin
            // Previous trig still high: hold one cycle so pulses stay separate.
            state_nxt = state;
        end else begin
            case (state)
                IDLE: begin
                    if ((q_count != 3'd0) && !playing) begin
                        pop        = 1'b1;
                        issue      = 1'b1;
                        issue_mode = fifo_mem[rd_ptr];
                        to_nxt     = '0;
                        state_nxt  = WAIT_START;
                    end
                end
                WAIT_START: begin
                    if (playing) begin
                        state_nxt = WAIT_DONE;
                    end else if (to_cnt == TO_LAST) begin
                        state_nxt = IDLE;
                    end else begin
                        to_nxt = to_cnt + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!playing) begin
                        if (GAP_NONE) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = GAP;
                            gap_nxt   = GAP_LOAD;
                        end
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state_nxt = IDLE;
                    end else begin
                        gap_nxt = gap_cnt - GW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_1mhz or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            q_count   <= '0;
            crit_pend <= 1'b0;
            crit_mode <= '0;
            snd_mode  <= '0;
            trig      <= 1'b0;
            drop      <= 1'b0;
            to_cnt    <= '0;
            gap_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            to_cnt  <= to_nxt;
            gap_cnt <= gap_nxt;
            trig    <= issue;
            drop    <= drop_nxt;
            if (issue) snd_mode <= issue_mode;

            // A newer critical request replaces one that has not issued yet.
            if (req_crit) begin
                crit_pend <= 1'b1;
                crit_mode <= req_mode;
            end else if (issue_crit) begin
                crit_pend <= 1'b0;
            end

            if (req_crit) begin
                wr_ptr  <= '0;
                rd_ptr  <= '0;
                q_count <= '0;
            end else begin
                if (push) wr_ptr <= ptr_inc(wr_ptr);
                if (pop)  rd_ptr <= ptr_inc(rd_ptr);
                q_count <= q_count + {2'b00, push} - {2'b00, pop};
            end
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (push) fifo_mem[wr_ptr] <= req_mode;
    end

endmodule

// File: tb/tb_snd_req_queue.sv
// tb/tb_snd_req_queue.sv - scoreboard bench for snd_req_queue
`timescale 1ns/1ps

module tb_snd_req_queue;

    logic       clk_1mhz = 1'b0;
    logic       rst;
    logic [6:0] ev_req;
    logic       playing;
    logic [2:0] snd_mode;
    logic       trig;
    logic       busy;
    logic [2:0] q_count;
    logic       drop;

    logic auto_play  = 1'b0;
    logic play_force = 1'b0;
    logic play_model = 1'b0;
    assign playing = auto_play ? play_model : play_force;

    int  checks = 0;
    int  errors = 0;
    int  exp_mode[$];
    int  exp_rd = 0;
    int  trig_cnt = 0;
    logic prev_trig = 1'b0;
    time fall_t = 0;
    int  fall_seq = 0;
    int  fall_used = 0;

    snd_req_queue dut (
        .clk_1mhz (clk_1mhz),
        .rst      (rst),
        .ev_req   (ev_req),
        .playing  (playing),
        .snd_mode (snd_mode),
        .trig     (trig),
        .busy     (busy),
        .q_count  (q_count),
        .drop     (drop)
    );

    always #5 clk_1mhz = ~clk_1mhz;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Scoreboard consumer: every trig must match the next expected mode.
    always @(negedge clk_1mhz) begin
        if (!rst && trig) begin
            check("trig_width", prev_trig, 0);
            check("trig_expected", exp_mode.size() > exp_rd, 1);
            if (exp_mode.size() > exp_rd) begin
                check("trig_mode", snd_mode, exp_mode[exp_rd]);
                exp_rd++;
            end
            if (fall_seq != fall_used) begin
                check("gap_cycles", (($time - fall_t) / 10) >= 20000, 1);
                fall_used = fall_seq;
            end
            trig_cnt++;
        end
        prev_trig = trig;
    end

    // Sound manager model: starts 2 cycles after trig, plays 400 cycles.
    always begin
        @(negedge clk_1mhz);
        if (auto_play && trig) begin
            repeat (2) @(negedge clk_1mhz);
            play_model = 1'b1;
            repeat (400) @(negedge clk_1mhz);
            play_model = 1'b0;
            fall_t = $time;
            fall_seq++;
        end
    end

    task automatic strobe(input logic [6:0] bits, input logic exp_drop, input string tag);
        ev_req = bits;
        @(negedge clk_1mhz);
        ev_req = '0;
        check(tag, drop, exp_drop);
    endtask

    initial begin
        int n;
        rst    = 1'b1;
        ev_req = '0;
        repeat (2) @(negedge clk_1mhz);
        check("rst_trig", trig, 0);
        check("rst_mode", snd_mode, 0);
        check("rst_busy", busy, 0);
        check("rst_qcount", q_count, 0);
        check("rst_drop", drop, 0);
        rst = 1'b0;
        @(negedge clk_1mhz);

        // Single hit with idle sound manager
        exp_mode.push_back(3);
        strobe(7'b0000100, 0, "hit_drop");
        check("hit_qcount_push", q_count, 1);
        check("hit_trig_early", trig, 0);
        @(negedge clk_1mhz);
        check("hit_trig", trig, 1);
        check("hit_mode", snd_mode, 3);
        check("hit_qcount_pop", q_count, 0);
        repeat (12) @(negedge clk_1mhz);
        check("hit_idle_busy", busy, 0);

        // Fill the queue while busy, overflow drops the fifth
        play_force = 1'b1;
        @(negedge clk_1mhz);
        exp_mode.push_back(2);
        exp_mode.push_back(3);
        exp_mode.push_back(4);
        exp_mode.push_back(5);
        strobe(7'b0000010, 0, "fill_drop_a");
        strobe(7'b0000100, 0, "fill_drop_b");
        strobe(7'b0001000, 0, "fill_drop_c");
        strobe(7'b0010000, 0, "fill_drop_d");
        check("fill_qcount", q_count, 4);
        strobe(7'b0000100, 1, "full_drop");
        check("full_qcount", q_count, 4);
        check("full_busy", busy, 1);
        @(negedge clk_1mhz);
        check("full_drop_once", drop, 0);
        play_force = 1'b0;
        repeat (50) @(negedge clk_1mhz);
        check("drain_qcount", q_count, 0);
        check("drain_trigs", trig_cnt, 5);

        // Repeated beep collapses silently
        play_force = 1'b1;
        exp_mode.push_back(1);
        strobe(7'b0000001, 0, "beep_drop");
        strobe(7'b0000001, 0, "beep_dup_drop");
        check("beep_dup_qcount", q_count, 1);
        play_force = 1'b0;
        repeat (15) @(negedge clk_1mhz);
        check("beep_drain_qcount", q_count, 0);

        // Critical flushes queue and preempts
        play_force = 1'b1;
        strobe(7'b0000010, 0, "pre_crit_a");
        strobe(7'b0000100, 0, "pre_crit_b");
        strobe(7'b0001000, 0, "pre_crit_c");
        check("pre_crit_qcount", q_count, 3);
        exp_mode.push_back(6);
        strobe(7'b0100000, 0, "crit_drop");
        check("crit_flush", q_count, 0);
        @(negedge clk_1mhz);
        check("crit_trig", trig, 1);
        check("crit_mode", snd_mode, 6);
        repeat (3) @(negedge clk_1mhz);

        // Reset in WAIT_DONE with two queued: queued requests are abandoned
        strobe(7'b0000010, 0, "wd_push_a");
        strobe(7'b0000100, 0, "wd_push_b");
        check("wd_qcount", q_count, 2);
        check("wd_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        check("arst_qcount", q_count, 0);
        check("arst_trig", trig, 0);
        check("arst_busy", busy, 0);
        @(negedge clk_1mhz);
        rst        = 1'b0;
        play_force = 1'b0;
        repeat (30) @(negedge clk_1mhz);
        check("post_rst_busy", busy, 0);
        check("post_rst_trigs", trig_cnt, 7);

        // Back-to-back criticals: second overwrites pending, issued after trig drops
        exp_mode.push_back(6);
        exp_mode.push_back(7);
        ev_req = 7'b0100000;
        @(negedge clk_1mhz);
        ev_req = 7'b1000000;
        @(negedge clk_1mhz);
        ev_req = '0;
        repeat (15) @(negedge clk_1mhz);
        check("crit_pair_trigs", trig_cnt, 9);

        // Multi-bit strobe: gameclear wins, beep dropped, start timeout
        exp_mode.push_back(7);
        strobe(7'b1000001, 1, "clear_drop");
        @(negedge clk_1mhz);
        check("clear_trig", trig, 1);
        check("clear_mode", snd_mode, 7);
        check("clear_drop_once", drop, 0);
        repeat (7) @(negedge clk_1mhz);
        check("timeout_busy_7", busy, 1);
        @(negedge clk_1mhz);
        check("timeout_busy_8", busy, 0);

        // Paced sequence with gap between sounds
        auto_play = 1'b1;
        exp_mode.push_back(3);
        exp_mode.push_back(4);
        exp_mode.push_back(5);
        ev_req = 7'b0000100;
        @(negedge clk_1mhz);
        ev_req = 7'b0001000;
        @(negedge clk_1mhz);
        ev_req = 7'b0010000;
        @(negedge clk_1mhz);
        ev_req = '0;
        n = 0;
        while (trig_cnt < 13 && n < 60000) begin
            @(negedge clk_1mhz);
            n++;
        end
        check("seq_trigs", trig_cnt, 13);
        check("seq_consumed", exp_rd, exp_mode.size());

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
